// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war playfield.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    ROUND_END = 2'd1,
    GAME_END  = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam int unsigned LFSR_W     = 10;
  localparam logic [9:0]  LFSR_SEED  = 10'h1;
  localparam int unsigned LFSR_TAP_A = 9;
  localparam int unsigned LFSR_TAP_B = 6;

  // Fibonacci step, taps 10 and 7 (bit indices 9 and 6).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/tug_key_edge.sv
// Rising-edge detector for one player key; the history register loads
// the live key every cycle, including during reset.
module tug_key_edge (
  input  logic clk,
  input  logic key,
  output logic press_c
);

  logic key_q;

  always_ff @(posedge clk) key_q <= key;

  assign press_c = key & ~key_q;

endmodule

// File: rtl/tug_field.sv
// Tug-of-war light bar with per-player scoring and round/game sequencing.
// Define TUG_CPU_PLAYER_EN to replace the right player with an LFSR opponent.
module tug_field
  import tug_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS = 9,
  parameter int unsigned SCORE_W    = 3,
  parameter int unsigned WIN_SCORE  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  l_key,
  input  logic                  r_key,
  input  logic                  restart,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]    left_score,
  output logic [SCORE_W-1:0]    right_score,
  output logic [1:0]            winner,
  output logic                  round_over,
  output logic                  game_over
);

  localparam int unsigned POS_W  = $clog2(NUM_LIGHTS);
  localparam int unsigned CENTER = (NUM_LIGHTS - 1) / 2;
  localparam int unsigned LAST   = NUM_LIGHTS - 1;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               lit_d;
  logic [SCORE_W-1:0] left_d, right_d;
  logic [1:0]         winner_d;
  logic               round_over_d, game_over_d;
  logic               l_press, r_press;

  tug_key_edge u_l_edge (
    .clk     (clk),
    .key     (l_key),
    .press_c (l_press)
  );

`ifdef TUG_CPU_PLAYER_EN
  logic [LFSR_W-1:0] lfsr_q;
  logic              unused_r_key;

  assign unused_r_key = r_key;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign r_press = (lfsr_q[3:0] == 4'h0) && (state_q == PLAY);
`else
  tug_key_edge u_r_edge (
    .clk     (clk),
    .key     (r_key),
    .press_c (r_press)
  );
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    lit_d        = (state_q == PLAY);
    left_d       = left_score;
    right_d      = right_score;
    winner_d     = winner;
    round_over_d = round_over;
    game_over_d  = game_over;

    case (state_q)
      PLAY: begin
        if (l_press && !r_press) begin
          if (pos_q == POS_W'(LAST)) begin
            lit_d    = 1'b0;
            left_d   = left_score + SCORE_W'(1);
            winner_d = WIN_LEFT;
            if (left_d == SCORE_W'(WIN_SCORE)) begin
              state_d     = GAME_END;
              game_over_d = 1'b1;
            end else begin
              state_d      = ROUND_END;
              round_over_d = 1'b1;
            end
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else if (r_press && !l_press) begin
          if (pos_q == '0) begin
            lit_d    = 1'b0;
            right_d  = right_score + SCORE_W'(1);
            winner_d = WIN_RIGHT;
            if (right_d == SCORE_W'(WIN_SCORE)) begin
              state_d     = GAME_END;
              game_over_d = 1'b1;
            end else begin
              state_d      = ROUND_END;
              round_over_d = 1'b1;
            end
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
      end
      ROUND_END: begin
        if (restart) begin
          state_d      = PLAY;
          pos_d        = POS_W'(CENTER);
          lit_d        = 1'b1;
          round_over_d = 1'b0;
        end
      end
      GAME_END: begin
        lit_d = 1'b0;
      end
      default: begin
        state_d = PLAY;
        pos_d   = POS_W'(CENTER);
        lit_d   = 1'b1;
      end
    endcase
  end

  // State and output registers; the bar is decoded to one-hot here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLAY;
      pos_q       <= POS_W'(CENTER);
      lights      <= NUM_LIGHTS'(1) << CENTER;
      left_score  <= '0;
      right_score <= '0;
      winner      <= WIN_NONE;
      round_over  <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      lights      <= lit_d ? (NUM_LIGHTS'(1) << pos_d) : '0;
      left_score  <= left_d;
      right_score <= right_d;
      winner      <= winner_d;
      round_over  <= round_over_d;
      game_over   <= game_over_d;
    end
  end

endmodule

// File: doc/tug_field.md
Name: tug_field

Overview:
- Parametrised tug-of-war playfield: an N-light bar with one lit position, moved by two player keys.
- Detects a round win when the light is pushed off either end, keeps per-player scores and declares game over at a target score.
- Sits between the key input synchronisers and the light/score display drivers.
- Generalises the single-position light cell into a full bar with scoring and round/game sequencing.

Parameters:
- NUM_LIGHTS, 9, number of lights in the bar; odd, >= 3.
- SCORE_W, 3, width of each score counter.
- WIN_SCORE, 7, score that ends the game; 1 .. 2**SCORE_W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- l_key  in  1  left player key, level, already synchronised.
- r_key  in  1  right player key, level, already synchronised.
- restart  in  1  single-cycle pulse; starts the next round after a round win.
- lights  out  NUM_LIGHTS  one-hot lit position; bit 0 is the rightmost light.
- left_score  out  SCORE_W  rounds won by the left player.
- right_score  out  SCORE_W  rounds won by the right player.
- winner  out  2  2'b00 none, 2'b01 left won last round, 2'b10 right won last round.
- round_over  out  1  high while waiting for restart.
- game_over  out  1  high once either score reaches WIN_SCORE.

Behaviour:
- Key edge detection:
  - A press is key & ~key_q, where key_q is the registered key.
  - key_q loads the live key during reset and in every state, so a held key never registers twice and a key held through reset or restart does not count.
- Press combinations:
  - Left press alone moves the light one index toward MSB.
  - Right press alone moves it toward index 0.
  - Both presses in the same cycle: no move.
- Reset values:
  - lights = one-hot at CENTER = (NUM_LIGHTS-1)/2.
  - Both scores 0, winner 2'b00, round_over 0, game_over 0.
  - State PLAY.
- FSM states PLAY, ROUND_END, GAME_END:
  - PLAY, left press with light at index NUM_LIGHTS-1:
    - lights <= 0; left_score++; winner <= 2'b01.
    - Next state is GAME_END if the new score == WIN_SCORE, else ROUND_END.
  - PLAY, right press with light at index 0: mirror case; winner <= 2'b10.
  - PLAY, otherwise: the light moves one step on the registered edge. Latency is press cycle +1.
  - ROUND_END:
    - round_over = 1, lights = 0, key presses ignored.
    - On restart: lights <= CENTER one-hot, round_over <= 0, state PLAY. winner holds until the next win.
  - GAME_END:
    - game_over = 1, round_over = 0, lights = 0.
    - restart and keys are ignored; only reset exits.
- Outputs are registered.
- Scores never wrap; WIN_SCORE bounds them.
- restart in PLAY or GAME_END has no effect.
- reset mid-round or mid-game returns all outputs to their reset values on the next edge.

Optional Feature:
- Macro: TUG_CPU_PLAYER_EN.
- When defined:
  - r_key is ignored and the right player is a built-in opponent.
  - A 10-bit Fibonacci LFSR (taps 10,7; seed 10'h1) advances every cycle and is reseeded on reset.
  - It generates a right press in any cycle where lfsr[3:0] == 4'h0, while in PLAY.
  - That press goes through the same both-press-cancels rule.
- When undefined: no LFSR logic; r_key is used as described above.

Decomposition:
- Package tug_pkg:
  - state enum {PLAY, ROUND_END, GAME_END}.
  - winner encodings WIN_NONE, WIN_LEFT, WIN_RIGHT.
  - LFSR seed and tap constants.
- Sub-module tug_key_edge:
  - Registered edge detector with load-on-reset.
  - Instantiated once per player; for the right player only when TUG_CPU_PLAYER_EN is undefined.
- The light position is held as a binary index and decoded to one-hot at the output register.

Test Plan:
1. Reset with NUM_LIGHTS=9 -> lights = 9'b000010000, scores 0, winner 0, round_over 0, game_over 0.
2. Four left presses, each a 1-cycle pulse with gaps -> lights 000100000, 001000000, 010000000, 100000000. A fifth press -> lights 0, left_score 1, winner 01, round_over 1.
3. l_key held high for 20 cycles in PLAY -> exactly one move. l_key and r_key rising in the same cycle -> lights unchanged.
4. In ROUND_END, apply presses then a restart pulse -> presses ignored; lights return to 000010000 the cycle after restart; round_over 0.
5. With WIN_SCORE=2, right wins two rounds -> right_score 2, game_over 1, winner 10. Subsequent restart and keys have no effect; reset clears everything.
6. Reset asserted mid-round at light index 7 with left_score 1 -> next edge gives centre light and scores 0. Under TUG_CPU_PLAYER_EN, with r_key tied 0, the light still moves right at LFSR-determined cycles matching a reference model.
